// File: rtl/mtrap_csr_pkg.sv
// Shared constants, context structs and mepc alignment helper for the trap CSR bank.
// Pure declarations: no state, no latency, no flow control.
package mtrap_csr_pkg;

  // Context fields are sized for the widest XLEN the bank is built with.
  localparam int CTX_XLEN = 32;

  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam logic [CTX_XLEN-1:0] CSR_RST_VAL = '0;

  typedef struct packed {
    logic [CTX_XLEN-1:0] epc;
    logic [CTX_XLEN-1:0] cause;
    logic [CTX_XLEN-1:0] tval;
  } ctx_t;

  typedef struct packed {
    logic [CTX_XLEN-1:0] epc;
    logic [CTX_XLEN-1:0] cause;
  } ctx_noval_t;

  function automatic logic [CTX_XLEN-1:0] align_epc(input logic [CTX_XLEN-1:0] pc,
                                                     input int ialign);
    logic [CTX_XLEN-1:0] m;
    m    = pc;
    m[0] = 1'b0;
    if (ialign != 16) m[1] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/mtrap_csr_bank_if.sv
// CSR / trap / mret port bundle between the pipeline (master) and the trap CSR bank (slave).
// Wires only; reads are combinational, events are single-cycle strobes with no backpressure.
interface mtrap_csr_bank_if #(
  parameter int XLEN       = 32,
  parameter int NEST_DEPTH = 4
);
  localparam int LW = $clog2(NEST_DEPTH + 1);

  logic            wr_en_in;
  logic [11:0]     csr_addr_in;
  logic [XLEN-1:0] data_wr_in;
  logic [XLEN-1:0] rd_data_out;
  logic            rd_hit_out;
  logic            trap_in;
  logic [XLEN-1:0] trap_pc_in;
  logic [XLEN-1:0] trap_cause_in;
  logic [XLEN-1:0] trap_val_in;
  logic            mret_in;
  logic [XLEN-1:0] mscratch_out;
  logic [XLEN-1:0] mepc_out;
  logic [XLEN-1:0] mcause_out;
  logic [XLEN-1:0] mtval_out;
  logic [XLEN-1:0] epc_out;
  logic [LW-1:0]   nest_level_out;
  logic            nest_overflow_out;

  modport master (
    output wr_en_in, csr_addr_in, data_wr_in, trap_in, trap_pc_in, trap_cause_in,
           trap_val_in, mret_in,
    input  rd_data_out, rd_hit_out, mscratch_out, mepc_out, mcause_out, mtval_out,
           epc_out, nest_level_out, nest_overflow_out
  );

  modport slave (
    input  wr_en_in, csr_addr_in, data_wr_in, trap_in, trap_pc_in, trap_cause_in,
           trap_val_in, mret_in,
    output rd_data_out, rd_hit_out, mscratch_out, mepc_out, mcause_out, mtval_out,
           epc_out, nest_level_out, nest_overflow_out
  );
endinterface

// File: rtl/epc_ctx_stack.sv
// LIFO of saved trap contexts; push/pop take effect on the next edge, top is combinational.
// No backpressure: push when full and pop when empty are ignored (the bank never issues them).
module epc_ctx_stack #(
  parameter int  DEPTH = 3,
  parameter type T     = mtrap_csr_pkg::ctx_t
) (
  input  logic clock,
  input  logic rst_n_in,
  input  logic i_push,
  input  logic i_pop,
  input  T     i_push_dat,
  output T     o_top_dat
);
  localparam int SD = (DEPTH < 1) ? 1 : DEPTH;
  localparam int PW = $clog2(SD + 1);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  T              r_mem [SD];
  logic [PW-1:0] r_cnt;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;

  assign w_wr_idx  = AW'(r_cnt);
  assign w_top_idx = AW'(r_cnt - PW'(1));
  assign o_top_dat = (r_cnt == '0) ? T'('0) : r_mem[w_top_idx];

  always_ff @(posedge clock or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
      for (int i = 0; i < SD; i++) r_mem[i] <= '0;
    end else if (i_push && (r_cnt < PW'(SD))) begin
      r_mem[w_wr_idx] <= i_push_dat;
      r_cnt           <= r_cnt + PW'(1);
    end else if (i_pop && (r_cnt != '0)) begin
      r_cnt <= r_cnt - PW'(1);
    end
  end
endmodule

// File: rtl/mtrap_csr_bank.sv
// Machine trap CSRs (mscratch/mepc/mcause[/mtval with MTRAP_MTVAL_EN]) plus nested-trap context LIFO.
// Reads combinational; trap > mret > CSR write, applied on the next edge; no backpressure.
module mtrap_csr_bank
  import mtrap_csr_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter int          IALIGN        = 32,
  parameter int          NEST_DEPTH    = 4,
  parameter logic [11:0] MSCRATCH_ADDR = CSR_MSCRATCH,
  parameter logic [11:0] MEPC_ADDR     = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR   = CSR_MCAUSE,
  parameter logic [11:0] MTVAL_ADDR    = CSR_MTVAL
) (
  input logic              clock,
  input logic              rst_n_in,
  mtrap_csr_bank_if.slave  bus
);
  localparam int            LW    = $clog2(NEST_DEPTH + 1);
  localparam logic [LW-1:0] L_MAX = LW'(NEST_DEPTH);

`ifdef MTRAP_MTVAL_EN
  typedef ctx_t stk_t;
`else
  typedef ctx_noval_t stk_t;
`endif

  logic [XLEN-1:0] r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [LW-1:0]   r_level;
  logic            r_ovf;
  logic            w_push, w_pop, w_wr;
  logic [XLEN-1:0] w_trap_epc, w_wr_epc, w_rd_data;
  logic            w_rd_hit;
  stk_t            w_push_ctx, w_top_ctx;

  assign w_trap_epc = XLEN'(align_epc(CTX_XLEN'(bus.trap_pc_in), IALIGN));
  assign w_wr_epc   = XLEN'(align_epc(CTX_XLEN'(bus.data_wr_in), IALIGN));
  // Level 0 has no live context and a full level has nowhere to put one.
  assign w_push     = bus.trap_in && (r_level != '0) && (r_level < L_MAX);
  assign w_pop      = !bus.trap_in && bus.mret_in && (r_level >= LW'(2));
  assign w_wr       = bus.wr_en_in && !bus.trap_in && !bus.mret_in;

  always_comb begin
    w_push_ctx       = '0;
    w_push_ctx.epc   = CTX_XLEN'(r_mepc);
    w_push_ctx.cause = CTX_XLEN'(r_mcause);
`ifdef MTRAP_MTVAL_EN
    w_push_ctx.tval  = CTX_XLEN'(r_mtval);
`endif
  end

  epc_ctx_stack #(.DEPTH(NEST_DEPTH - 1), .T(stk_t)) u_stack (
    .clock      (clock),
    .rst_n_in   (rst_n_in),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_dat (w_push_ctx),
    .o_top_dat  (w_top_ctx)
  );

  always_ff @(posedge clock or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mscratch <= XLEN'(CSR_RST_VAL);
      r_mepc     <= XLEN'(CSR_RST_VAL);
      r_mcause   <= XLEN'(CSR_RST_VAL);
      r_mtval    <= XLEN'(CSR_RST_VAL);
      r_level    <= '0;
      r_ovf      <= 1'b0;
    end else if (bus.trap_in) begin
      r_mepc   <= w_trap_epc;
      r_mcause <= bus.trap_cause_in;
`ifdef MTRAP_MTVAL_EN
      r_mtval  <= bus.trap_val_in;
`endif
      if (r_level == L_MAX) r_ovf   <= 1'b1;
      else                  r_level <= r_level + LW'(1);
    end else if (bus.mret_in) begin
      if (w_pop) begin
        r_mepc   <= XLEN'(w_top_ctx.epc);
        r_mcause <= XLEN'(w_top_ctx.cause);
`ifdef MTRAP_MTVAL_EN
        r_mtval  <= XLEN'(w_top_ctx.tval);
`endif
        r_level  <= r_level - LW'(1);
      end else if (r_level == LW'(1)) begin
        r_level <= '0;
        r_ovf   <= 1'b0;
      end
    end else if (w_wr) begin
      case (bus.csr_addr_in)
        MSCRATCH_ADDR: r_mscratch <= bus.data_wr_in;
        MEPC_ADDR:     r_mepc     <= w_wr_epc;
        MCAUSE_ADDR:   r_mcause   <= bus.data_wr_in;
`ifdef MTRAP_MTVAL_EN
        MTVAL_ADDR:    r_mtval    <= bus.data_wr_in;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_hit  = 1'b0;
    case (bus.csr_addr_in)
      MSCRATCH_ADDR: begin w_rd_data = r_mscratch; w_rd_hit = 1'b1; end
      MEPC_ADDR:     begin w_rd_data = r_mepc;     w_rd_hit = 1'b1; end
      MCAUSE_ADDR:   begin w_rd_data = r_mcause;   w_rd_hit = 1'b1; end
`ifdef MTRAP_MTVAL_EN
      MTVAL_ADDR:    begin w_rd_data = r_mtval;    w_rd_hit = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign bus.rd_data_out       = w_rd_data;
  assign bus.rd_hit_out        = w_rd_hit;
  assign bus.mscratch_out      = r_mscratch;
  assign bus.mepc_out          = r_mepc;
  assign bus.mcause_out        = r_mcause;
`ifdef MTRAP_MTVAL_EN
  assign bus.mtval_out         = r_mtval;
`else
  assign bus.mtval_out         = '0;
`endif
  assign bus.epc_out           = r_mepc;
  assign bus.nest_level_out    = r_level;
  assign bus.nest_overflow_out = r_ovf;
endmodule

// File: tb/tb_mtrap_csr_bank.sv
// Bench for mtrap_csr_bank: directed scenarios then random traffic against a queue-based context model.
module tb_mtrap_csr_bank;
  localparam int D = 4;
`ifdef MTRAP_MTVAL_EN
  localparam bit MTVAL_ON = 1'b1;
`else
  localparam bit MTVAL_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_n_in = 1'b1;
  always #5 clock = ~clock;

  mtrap_csr_bank_if #(.XLEN(32), .NEST_DEPTH(D)) bus ();
  mtrap_csr_bank_if #(.XLEN(32), .NEST_DEPTH(D)) bus16 ();

  mtrap_csr_bank #(.XLEN(32), .IALIGN(32), .NEST_DEPTH(D)) dut (
    .clock(clock), .rst_n_in(rst_n_in), .bus(bus.slave));
  mtrap_csr_bank #(.XLEN(32), .IALIGN(16), .NEST_DEPTH(D)) dut16 (
    .clock(clock), .rst_n_in(rst_n_in), .bus(bus16.slave));

  typedef struct {
    logic [31:0] e;
    logic [31:0] c;
    logic [31:0] v;
  } mctx_t;

  logic [31:0] m_scr, m_epc, m_cause, m_tval;
  int          m_lvl;
  bit          m_ovf;
  mctx_t       m_stk[$];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_align(input logic [31:0] pc, input int ia);
    return (ia == 16) ? (pc & ~32'h1) : (pc & ~32'h3);
  endfunction

  task automatic m_reset();
    m_scr = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_lvl = 0; m_ovf = 0;
    m_stk.delete();
  endtask

  task automatic m_step(input bit trap, input bit mret, input bit wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [31:0] pc,
                        input logic [31:0] cause, input logic [31:0] val);
    mctx_t c;
    if (trap) begin
      if (m_lvl >= 1 && m_lvl < D) m_stk.push_back('{m_epc, m_cause, m_tval});
      if (m_lvl == D) m_ovf = 1;
      else m_lvl++;
      m_epc = m_align(pc, 32);
      m_cause = cause;
      if (MTVAL_ON) m_tval = val;
    end else if (mret) begin
      if (m_lvl >= 2) begin
        c = m_stk.pop_back();
        m_epc = c.e; m_cause = c.c; m_tval = c.v;
        m_lvl--;
      end else if (m_lvl == 1) begin
        m_lvl = 0; m_ovf = 0;
      end
    end else if (wr) begin
      case (addr)
        12'h340: m_scr = data;
        12'h341: m_epc = m_align(data, 32);
        12'h342: m_cause = data;
        12'h343: if (MTVAL_ON) m_tval = data;
        default: ;
      endcase
    end
  endtask

  task automatic m_read(input logic [11:0] addr, output logic [31:0] d, output bit hit);
    d = 0; hit = 0;
    if (addr == 12'h340) begin d = m_scr; hit = 1; end
    if (addr == 12'h341) begin d = m_epc; hit = 1; end
    if (addr == 12'h342) begin d = m_cause; hit = 1; end
    if (addr == 12'h343 && MTVAL_ON) begin d = m_tval; hit = 1; end
  endtask

  task automatic check_state();
    chk("mscratch", bus.mscratch_out, m_scr);
    chk("mepc", bus.mepc_out, m_epc);
    chk("mcause", bus.mcause_out, m_cause);
    chk("mtval", bus.mtval_out, m_tval);
    chk("epc_out", bus.epc_out, m_epc);
    chk("level", bus.nest_level_out, m_lvl);
    chk("overflow", bus.nest_overflow_out, m_ovf);
  endtask

  task automatic idle();
    bus.trap_in = 0; bus.mret_in = 0; bus.wr_en_in = 0;
  endtask

  task automatic check_read(input logic [11:0] addr);
    logic [31:0] d;
    bit h;
    idle();
    bus.csr_addr_in = addr;
    #1;
    m_read(addr, d, h);
    chk("rd_data", bus.rd_data_out, d);
    chk("rd_hit", bus.rd_hit_out, h);
  endtask

  task automatic cycle(input bit trap, input bit mret, input bit wr, input logic [11:0] addr,
                       input logic [31:0] data, input logic [31:0] pc,
                       input logic [31:0] cause, input logic [31:0] val);
    bus.trap_in = trap; bus.mret_in = mret; bus.wr_en_in = wr;
    bus.csr_addr_in = addr; bus.data_wr_in = data;
    bus.trap_pc_in = pc; bus.trap_cause_in = cause; bus.trap_val_in = val;
    @(posedge clock);
    m_step(trap, mret, wr, addr, data, pc, cause, val);
    #1;
    check_state();
    idle();
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause);
    cycle(1, 0, 0, 12'h0, 0, pc, cause, pc ^ 32'hA5A5_0000);
  endtask

  task automatic do_mret();
    cycle(0, 1, 0, 12'h0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    bus.csr_addr_in = 0; bus.data_wr_in = 0;
    bus.trap_pc_in = 0; bus.trap_cause_in = 0; bus.trap_val_in = 0;
    bus16.trap_in = 0; bus16.mret_in = 0; bus16.wr_en_in = 0;
    bus16.csr_addr_in = 0; bus16.data_wr_in = 0;
    bus16.trap_pc_in = 0; bus16.trap_cause_in = 0; bus16.trap_val_in = 0;
    m_reset();

    #2 rst_n_in = 0;
    #1 check_state();
    repeat (2) @(posedge clock);
    @(negedge clock) rst_n_in = 1;
    for (int a = 'h340; a <= 'h344; a++) check_read(12'(a));

    // Misaligned mepc write on both alignment variants.
    bus16.wr_en_in = 1; bus16.csr_addr_in = 12'h341; bus16.data_wr_in = 32'h8000_0007;
    cycle(0, 0, 1, 12'h341, 32'h8000_0007, 0, 0, 0);
    bus16.wr_en_in = 0;
    chk("mepc_ialign32", bus.mepc_out, 32'h8000_0004);
    chk("mepc_ialign16", bus16.mepc_out, 32'h8000_0006);
    cycle(0, 0, 1, 12'h340, 32'hDEAD_BEEF, 0, 0, 0);
    cycle(0, 0, 1, 12'h343, 32'h1234_5678, 0, 0, 0);
    check_read(12'h340);
    check_read(12'h343);

    // Three nested traps then three mrets.
    do_trap(32'h100, 2);
    do_trap(32'h200, 3);
    do_trap(32'h300, 4);
    chk("nest3_level", bus.nest_level_out, 3);
    chk("nest3_epc", bus.epc_out, 32'h300);
    do_mret(); chk("mret1_epc", bus.epc_out, 32'h200);
    do_mret(); chk("mret2_epc", bus.epc_out, 32'h100);
    do_mret(); chk("mret3_epc", bus.epc_out, 32'h100);
    chk("mret3_level", bus.nest_level_out, 0);

    // Overflow: five traps at depth four, then unwind.
    for (int i = 1; i <= 5; i++) do_trap(32'h1000 * i, 32'(i));
    chk("ovf_level", bus.nest_level_out, 4);
    chk("ovf_flag", bus.nest_overflow_out, 1);
    chk("ovf_epc", bus.mepc_out, 32'h5000);
    for (int i = 0; i < 4; i++) do_mret();
    chk("ovf_clear", bus.nest_overflow_out, 0);

    // Trap, mret and write all at once: trap wins.
    cycle(1, 1, 1, 12'h341, 32'hFFFF_FFF0, 32'h444, 9, 0);
    chk("prio_epc", bus.epc_out, 32'h444);
    chk("prio_level", bus.nest_level_out, 1);

    // Asynchronous reset at level 2, mid-cycle.
    do_trap(32'h888, 5);
    #2 rst_n_in = 0;
    m_reset();
    #1 check_state();
    chk("rst_rd", bus.rd_data_out, 0);
    @(negedge clock) rst_n_in = 1;
    do_mret();

    for (int n = 0; n < 1500; n++) begin
      int r;
      bit t, m, w;
      r = $urandom_range(0, 99);
      t = (r < 30);
      m = (r >= 30 && r < 55);
      w = (r >= 55 && r < 95) || ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin t = 1; m = 1; end
      cycle(t, m, w, 12'($urandom_range('h33f, 'h345)), $urandom, $urandom, $urandom, $urandom);
      check_read(12'($urandom_range('h33f, 'h345)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
